ir_queue: RTL and testbench
===========================

# ir_queue

Parametrised instruction register and queue for the LC-3b datapath, placed between the memory fetch path and the control/decode logic. It buffers up to DEPTH fetched instruction words, each tagged with its fetch PC, behind a valid/ready handshake. It presents the fully decoded fields of the head entry, adding sign-extended offsets, a PC+2 value and a flush.

## Interface
- DEPTH, default 4: number of entries; must be a power of two, minimum 2.
- WIDTH, default 16: instruction and PC word width; only 16 is supported for decode.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous discard of all entries (branch redirect).
- in_valid  in  1  fetch side presents a word.
- in_ready  out  1  queue accepts the word this cycle.
- in  in  WIDTH  instruction word.
- in_pc  in  WIDTH  address the word was fetched from.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- opcode  out  4  head [15:12], typed lc3b_opcode.
- dest, src1, src2  out  3 each  head [11:9], [8:6], [2:0].
- offset6, offset9, offset11  out  6/9/11  raw head [5:0], [8:0], [10:0].
- sext6, sext9, sext11  out  16 each  sign-extended offset6/9/11.
- imm5, imm4, trapvect  out  5/4/8  head [4:0], [3:0], [7:0].
- sext5  out  16  sign-extended imm5.
- imm_check, jsr_check, shf_a, shf_d  out  1 each  head bits 5, 11, 5, 4.
- pc, pc_plus2  out  16 each  head fetch PC and PC+2, mod 2^16.

## Operation
- Circular buffer with read pointer, write pointer and count. Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Push occurs when in_valid && in_ready, storing {in, in_pc} at the write pointer.
- Pop occurs when out_valid && out_ready, advancing the read pointer.
- in_ready = (count != DEPTH) && !flush. A full queue does not accept a push even while popping in the same cycle.
- out_valid = (count != 0).
- Push and pop in the same cycle (not full, not empty): count is unchanged and both pointers advance.
- flush has priority over push and pop. Pointers and count go to 0 on the next edge, and any word offered that cycle is dropped.
- All decode outputs are combinational from the head entry. When out_valid = 0 they are forced to 0, with opcode = 4'b0000.
- Sign extension replicates the top bit of the field into bits [15:n]. pc_plus2 = pc + 2 and discards the carry.
- in_valid with in_ready low is legal: the producer holds the word and no state changes.
- out_ready with out_valid low is ignored.

## Timing
- Reset (asynchronous) clears pointers, count and storage. After reset: in_ready = 1, out_valid = 0, count = 0, and all decode outputs are 0.
- Release of reset is synchronised externally; the first push is allowed on the first edge after deassertion.
- Latency: a word pushed at edge N is at the head with out_valid = 1 after edge N, provided the queue was empty. There is no same-cycle bypass.
- Throughput is one push and one pop per cycle in steady state.
- in_ready and out_valid depend only on registered state and flush. There is no combinational path from out_ready to in_ready.
- Reset asserted mid-stream aborts every entry. No partial state survives.

## Structure
- lc3b_types already holds lc3b_word, lc3b_opcode, lc3b_reg, lc3b_offset6 and lc3b_offset9. Add lc3b_offset11, lc3b_imm5, lc3b_imm4 and lc3b_trapvect there.
- Add a generic sext function to lc3b_types, parametrised by field width.
- One sub-module, ir_decode: purely combinational, taking {word, pc, valid} and producing every decode output. The ir_queue top holds only storage, pointers and handshake.

## Test plan
- Reset, then push 0x12BD at PC 0x3000 → next cycle out_valid = 1, opcode = 0001, dest = 1, src1 = 2, imm_check = 1, imm5 = 0x1D, sext5 = 0xFFFD, pc_plus2 = 0x3002.
- Push 0x0FFF, 0x4FFF, 0xF025, 0xD284 back-to-back, then drain one per cycle. Required in order:
  - sext9 = 0xFFFF;
  - jsr_check = 1, sext11 = 0xFFFF;
  - trapvect = 0x25;
  - imm4 = 4, shf_a = 0, shf_d = 0.
- With DEPTH = 4: push 4 words with out_ready = 0 → count = 4 and in_ready = 0. A fifth word is held, not lost. Pop one → the fifth is accepted next cycle and wrap-around preserves order across more than 8 pushes.
- Hold in_valid and out_ready at 1 for 20 cycles with incrementing words → count stays 1 and every word appears exactly once, in order.
- Fill 3 entries, then assert flush together with in_valid → next cycle count = 0, out_valid = 0, and the offered word is absent.
- Assert reset asynchronously mid-cycle with 2 entries queued → out_valid drops without waiting for a clock edge, and decode outputs read 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, field widths and the generic sign-extension helper.
package lc3b_types;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [2:0]        lc3b_reg;
    typedef logic [5:0]        lc3b_offset6;
    typedef logic [8:0]        lc3b_offset9;
    typedef logic [10:0]       lc3b_offset11;
    typedef logic [4:0]        lc3b_imm5;
    typedef logic [3:0]        lc3b_imm4;
    typedef logic [7:0]        lc3b_trapvect;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    // Sign-extend the low n bits of raw into a full word (bit n-1 copied into [15:n]).
    function automatic lc3b_word sext(input lc3b_word raw, input int unsigned n);
        lc3b_word mask;
        mask = 16'hFFFF << n;
        return raw[4'(n - 1)] ? (raw | mask) : (raw & ~mask);
    endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational field decode of the queue head; everything reads zero when the head is invalid.
module ir_decode
    import lc3b_types::*;
(
    input  lc3b_word     word,
    input  lc3b_word     pc_in,
    input  logic         valid,
    output lc3b_opcode   opcode,
    output lc3b_reg      dest,
    output lc3b_reg      src1,
    output lc3b_reg      src2,
    output lc3b_offset6  offset6,
    output lc3b_offset9  offset9,
    output lc3b_offset11 offset11,
    output lc3b_word     sext6,
    output lc3b_word     sext9,
    output lc3b_word     sext11,
    output lc3b_imm5     imm5,
    output lc3b_imm4     imm4,
    output lc3b_trapvect trapvect,
    output lc3b_word     sext5,
    output logic         imm_check,
    output logic         jsr_check,
    output logic         shf_a,
    output logic         shf_d,
    output lc3b_word     pc,
    output lc3b_word     pc_plus2
);

    lc3b_word w;
    lc3b_word p;

    // Gate the head word and PC so an empty queue presents all-zero fields.
    always_comb begin
        w = valid ? word  : '0;
        p = valid ? pc_in : '0;
    end

    // Slice the instruction fields and build the extended offsets.
    always_comb begin
        opcode    = lc3b_opcode'(w[15:12]);
        dest      = w[11:9];
        src1      = w[8:6];
        src2      = w[2:0];
        offset6   = w[5:0];
        offset9   = w[8:0];
        offset11  = w[10:0];
        imm5      = w[4:0];
        imm4      = w[3:0];
        trapvect  = w[7:0];
        imm_check = w[5];
        jsr_check = w[11];
        shf_a     = w[5];
        shf_d     = w[4];
        sext5     = sext(16'(w[4:0]), 5);
        sext6     = sext(16'(w[5:0]), 6);
        sext9     = sext(16'(w[8:0]), 9);
        sext11    = sext(16'(w[10:0]), 11);
        pc        = p;
        pc_plus2  = valid ? (p + 16'd2) : '0;
    end

endmodule

// File: rtl/ir_queue.sv
// Instruction register queue: circular buffer of {word, fetch PC} with valid/ready on both sides.
module ir_queue
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in,
    input  logic [WIDTH-1:0]         in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output lc3b_opcode               opcode,
    output logic [2:0]               dest,
    output logic [2:0]               src1,
    output logic [2:0]               src2,
    output logic [5:0]               offset6,
    output logic [8:0]               offset9,
    output logic [10:0]              offset11,
    output logic [15:0]              sext6,
    output logic [15:0]              sext9,
    output logic [15:0]              sext11,
    output logic [4:0]               imm5,
    output logic [3:0]               imm4,
    output logic [7:0]               trapvect,
    output logic [15:0]              sext5,
    output logic                     imm_check,
    output logic                     jsr_check,
    output logic                     shf_a,
    output logic                     shf_d,
    output logic [15:0]              pc,
    output logic [15:0]              pc_plus2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] word_mem_q [DEPTH];
    logic [WIDTH-1:0] word_mem_d [DEPTH];
    logic [WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [WIDTH-1:0] pc_mem_d   [DEPTH];

    logic push;
    logic pop;

    // Handshake: driven only by registered occupancy and flush, never by out_ready.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH)) && !flush;
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready && !flush;
        count     = count_q;
    end

    // Next-state for pointers, occupancy and storage; flush discards everything.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        word_mem_d = word_mem_q;
        pc_mem_d   = pc_mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                word_mem_d[wr_ptr_q] = in;
                pc_mem_d[wr_ptr_q]   = in_pc;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset wipes pointers, occupancy and storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                word_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            word_mem_q <= word_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

    ir_decode u_decode (
        .word      (16'(word_mem_q[rd_ptr_q])),
        .pc_in     (16'(pc_mem_q[rd_ptr_q])),
        .valid     (out_valid),
        .opcode    (opcode),
        .dest      (dest),
        .src1      (src1),
        .src2      (src2),
        .offset6   (offset6),
        .offset9   (offset9),
        .offset11  (offset11),
        .sext6     (sext6),
        .sext9     (sext9),
        .sext11    (sext11),
        .imm5      (imm5),
        .imm4      (imm4),
        .trapvect  (trapvect),
        .sext5     (sext5),
        .imm_check (imm_check),
        .jsr_check (jsr_check),
        .shf_a     (shf_a),
        .shf_d     (shf_d),
        .pc        (pc),
        .pc_plus2  (pc_plus2)
    );

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_ir_queue;
    import lc3b_types::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] in_w, in_pc;
    logic        in_ready, out_valid;
    logic [$clog2(DEPTH):0] count;
    lc3b_opcode  opcode;
    logic [2:0]  dest, src1, src2;
    logic [5:0]  offset6;
    logic [8:0]  offset9;
    logic [10:0] offset11;
    logic [15:0] sext6, sext9, sext11, sext5, pc, pc_plus2;
    logic [4:0]  imm5;
    logic [3:0]  imm4;
    logic [7:0]  trapvect;
    logic        imm_check, jsr_check, shf_a, shf_d;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    typedef struct {
        int word;
        int pc;
    } ent_t;
    ent_t mq[$];

    ir_queue #(.DEPTH(DEPTH), .WIDTH(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in(in_w), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .offset6(offset6), .offset9(offset9), .offset11(offset11),
        .sext6(sext6), .sext9(sext9), .sext11(sext11),
        .imm5(imm5), .imm4(imm4), .trapvect(trapvect), .sext5(sext5),
        .imm_check(imm_check), .jsr_check(jsr_check), .shf_a(shf_a), .shf_d(shf_d),
        .pc(pc), .pc_plus2(pc_plus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Two's-complement value of an n-bit field, re-expressed as a 16-bit word.
    function automatic int m_sext(input int field, input int bits);
        int v;
        v = field % (1 << bits);
        if (v >= (1 << (bits - 1))) v = v - (1 << bits);
        return (v + 65536) % 65536;
    endfunction

    // Reference model: an ordered list of entries updated by the handshake rules.
    always @(posedge clk) begin
        if (!reset) begin
            bit pu, po;
            pu = in_valid && (mq.size() != DEPTH) && !flush;
            po = (mq.size() != 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (po) void'(mq.pop_front());
                if (pu) mq.push_back('{int'(in_w), int'(in_pc)});
            end
        end
    end

    always @(posedge reset) mq.delete();

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (!reset && chk_en) begin
            int w, p;
            bit v;
            v = (mq.size() != 0);
            w = v ? mq[0].word : 0;
            p = v ? mq[0].pc   : 0;
            chk("in_ready",  in_ready,  (mq.size() != DEPTH) && !flush);
            chk("out_valid", out_valid, v);
            chk("count",     count,     mq.size());
            chk("opcode",    opcode,    w / 4096);
            chk("dest",      dest,      (w / 512) % 8);
            chk("src1",      src1,      (w / 64) % 8);
            chk("src2",      src2,      w % 8);
            chk("offset6",   offset6,   w % 64);
            chk("offset9",   offset9,   w % 512);
            chk("offset11",  offset11,  w % 2048);
            chk("sext6",     sext6,     m_sext(w, 6));
            chk("sext9",     sext9,     m_sext(w, 9));
            chk("sext11",    sext11,    m_sext(w, 11));
            chk("imm5",      imm5,      w % 32);
            chk("imm4",      imm4,      w % 16);
            chk("trapvect",  trapvect,  w % 256);
            chk("sext5",     sext5,     m_sext(w, 5));
            chk("imm_check", imm_check, (w / 32) % 2);
            chk("jsr_check", jsr_check, (w / 2048) % 2);
            chk("shf_a",     shf_a,     (w / 32) % 2);
            chk("shf_d",     shf_d,     (w / 16) % 2);
            chk("pc",        pc,        p);
            chk("pc_plus2",  pc_plus2,  v ? (p + 2) % 65536 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_w = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Post-reset state.
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count",     count,     0);
        chk("rst_opcode",    opcode,    0);
        chk("rst_sext5",     sext5,     0);
        chk("rst_pc_plus2",  pc_plus2,  0);

        // Single ADD-immediate word.
        in_valid = 1'b1; in_w = 16'h12BD; in_pc = 16'h3000;
        cyc();
        in_valid = 1'b0;
        chk("add_out_valid", out_valid, 1);
        chk("add_opcode",    opcode,    4'b0001);
        chk("add_dest",      dest,      1);
        chk("add_src1",      src1,      2);
        chk("add_imm_check", imm_check, 1);
        chk("add_imm5",      imm5,      5'h1D);
        chk("add_sext5",     sext5,     16'hFFFD);
        chk("add_pc_plus2",  pc_plus2,  16'h3002);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("add_drained", out_valid, 0);

        // Back-to-back pushes of four formats, then drain one per cycle.
        in_valid = 1'b1;
        in_w = 16'h0FFF; in_pc = 16'h3100; cyc();
        in_w = 16'h4FFF; in_pc = 16'h3102; cyc();
        in_w = 16'hF025; in_pc = 16'h3104; cyc();
        in_w = 16'hD284; in_pc = 16'h3106; cyc();
        in_valid = 1'b0;
        chk("fmt_count", count, 4);
        out_ready = 1'b1;
        chk("br_sext9", sext9, 16'hFFFF);
        cyc();
        chk("jsr_check", jsr_check, 1);
        chk("jsr_sext11", sext11, 16'hFFFF);
        cyc();
        chk("trap_vect", trapvect, 8'h25);
        cyc();
        chk("shf_imm4", imm4, 4);
        chk("shf_a_lit", shf_a, 0);
        chk("shf_d_lit", shf_d, 0);
        cyc();
        out_ready = 1'b0;
        chk("fmt_empty", count, 0);

        // Fill to full, hold a fifth word, then wrap the pointers repeatedly.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_w = 16'h1000 + 16'(i); in_pc = 16'h5000 + 16'(2 * i);
            cyc();
        end
        in_w = 16'h1004; in_pc = 16'h5008;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        cyc();
        chk("held_count", count, 4);
        chk("held_head_pc", pc, 16'h5000);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("after_pop_count", count, 3);
        chk("after_pop_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("fifth_accepted", count, 4);
        for (int i = 5; i < 10; i++) begin
            chk("wrap_head_pc", pc, 16'h5000 + 16'(2 * (i - 4)));
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
            in_valid = 1'b1; in_w = 16'h1000 + 16'(i); in_pc = 16'h5000 + 16'(2 * i);
            cyc();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        for (int i = 6; i < 10; i++) begin
            chk("wrap_drain_pc", pc, 16'h5000 + 16'(2 * i));
            cyc();
        end
        out_ready = 1'b0;
        chk("wrap_empty", out_valid, 0);

        // Streaming push and pop every cycle.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_w = 16'h2000 + 16'(i); in_pc = 16'h6000 + 16'(2 * i);
            cyc();
            chk("stream_count", count, 1);
            chk("stream_pc", pc, 16'h6000 + 16'(2 * i));
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        chk("stream_empty", count, 0);

        // Flush with a word offered in the same cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_w = 16'h3000 + 16'(i); in_pc = 16'h7000 + 16'(2 * i);
            cyc();
        end
        chk("preflush_count", count, 3);
        in_w = 16'hBEEF; in_pc = 16'h7100; flush = 1'b1;
        cyc();
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        cyc();
        chk("flush_word_absent", out_valid, 0);

        // Asynchronous reset mid-cycle with two entries queued.
        in_valid = 1'b1;
        in_w = 16'h1234; in_pc = 16'h7200; cyc();
        in_w = 16'h5678; in_pc = 16'h7202; cyc();
        in_valid = 1'b0;
        chk("prereset_count", count, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count",     count,     0);
        chk("arst_opcode",    opcode,    0);
        chk("arst_pc",        pc,        0);
        chk("arst_sext9",     sext9,     0);
        chk("arst_in_ready",  in_ready,  1);
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b1; in_w = 16'h1ABC; in_pc = 16'h8000;
        cyc();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_pc",    pc,        16'h8000);
        chk("post_rst_count", count,     1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
